// File: rtl/fios_casc_pkg.sv
// Shared types and DSP OPMODE constants for the FIOS cascade controller.
package fios_casc_pkg;

    localparam int unsigned IDX_W    = 6;
    localparam int unsigned OPMODE_W = 9;
    localparam int unsigned CNT_W    = 16;

    localparam logic [OPMODE_W-1:0] OPMODE_MUL_C          = 9'h185;
    localparam logic [OPMODE_W-1:0] OPMODE_MUL_PCIN_SHR17 = 9'h055;
    localparam logic [OPMODE_W-1:0] OPMODE_IDLE           = 9'h000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Control word presented to the DSP slice in one cycle
    typedef struct packed {
        logic [OPMODE_W-1:0] opmode;
        logic                creg_en;
        logic [IDX_W-1:0]    a_idx;
        logic [IDX_W-1:0]    b_idx;
    } dsp_ctrl_t;

    // First word of each row restarts the sum from C; later words fold in PCIN>>17
    function automatic dsp_ctrl_t issue_ctrl(input logic [IDX_W-1:0] i,
                                             input logic [IDX_W-1:0] j);
        dsp_ctrl_t c;
        c.a_idx   = i;
        c.b_idx   = j;
        c.creg_en = (j == '0);
        c.opmode  = (j == '0) ? OPMODE_MUL_C : OPMODE_MUL_PCIN_SHR17;
        return c;
    endfunction

endpackage

// File: rtl/fios_delay_line.sv
// Resettable shift register of configurable depth and width.
module fios_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                stage[k] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int k = 1; k < int'(DEPTH); k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/fios_casc_ctrl.sv
// Sequencer for a cascaded DSP58 FIOS multiply: issues all i/j word pairs then drains.
// Optional FIOS_CASC_CTRL_CYCLE_CNT_EN adds a saturating per-operation cycle counter.
module fios_casc_ctrl
    import fios_casc_pkg::*;
#(
    parameter int unsigned ABREG      = 1,
    parameter int unsigned MREG       = 1,
    parameter int unsigned WORD_COUNT = 8
) (
    input  logic                clock_i,
    input  logic                rst_n_i,
    input  logic                start_i,
    output logic                ready_o,
    output logic [OPMODE_W-1:0] opmode_o,
    output logic                creg_en_o,
    output logic [IDX_W-1:0]    a_idx_o,
    output logic [IDX_W-1:0]    b_idx_o,
    output logic                p_valid_o,
    output logic                p_last_o,
    output logic                done_o
`ifdef FIOS_CASC_CTRL_CYCLE_CNT_EN
    ,
    output logic [CNT_W-1:0]    cycle_cnt_o
`endif
);

    localparam int unsigned    DSP_REG_LEVEL = 1 + ABREG + MREG;
    localparam int unsigned    DRAIN_W       = $clog2(DSP_REG_LEVEL + 1);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(WORD_COUNT - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DSP_REG_LEVEL - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   i_q, i_d;
    logic [IDX_W-1:0]   j_q, j_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    dsp_ctrl_t          ctrl_q, ctrl_d;
    logic               ready_d;
    logic               done_d;
    logic               issue_c;
    logic               last_c;

    always_ff @(posedge clock_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            drain_q <= '0;
            ctrl_q  <= '0;
            ready_o <= 1'b1;
            done_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            drain_q <= drain_d;
            ctrl_q  <= ctrl_d;
            ready_o <= ready_d;
            done_o  <= done_d;
        end
    end

    // Next state, indices, and the control word for the cycle being entered
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        drain_d = drain_q;
        ctrl_d  = '0;
        ctrl_d.opmode = OPMODE_IDLE;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = ISSUE;
                    i_d     = '0;
                    j_d     = '0;
                end
            end
            ISSUE: begin
                if (j_q == LAST_IDX) begin
                    j_d = '0;
                    if (i_q == LAST_IDX) begin
                        state_d = DRAIN;
                        i_d     = '0;
                        drain_d = '0;
                    end else begin
                        i_d = IDX_W'(i_q + IDX_W'(1));
                    end
                end else begin
                    j_d = IDX_W'(j_q + IDX_W'(1));
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = DONE;
                    drain_d = '0;
                end else begin
                    drain_d = DRAIN_W'(drain_q + DRAIN_W'(1));
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == ISSUE) begin
            ctrl_d = issue_ctrl(i_d, j_d);
        end
        ready_d = (state_d == IDLE);
        done_d  = (state_d == DONE);
    end

    assign opmode_o  = ctrl_q.opmode;
    assign creg_en_o = ctrl_q.creg_en;
    assign a_idx_o   = ctrl_q.a_idx;
    assign b_idx_o   = ctrl_q.b_idx;

    // Issue flags enter the delay line in the same cycle the DSP sees the operands
    assign issue_c = (state_q == ISSUE);
    assign last_c  = issue_c && (i_q == LAST_IDX) && (j_q == LAST_IDX);

    fios_delay_line #(
        .DEPTH (DSP_REG_LEVEL),
        .WIDTH (2)
    ) u_p_delay (
        .clk   (clock_i),
        .rst_n (rst_n_i),
        .din   ({last_c, issue_c}),
        .dout  ({p_last_o, p_valid_o})
    );

`ifdef FIOS_CASC_CTRL_CYCLE_CNT_EN
    // Counts busy cycles of the current operation; holds through IDLE
    always_ff @(posedge clock_i) begin
        if (!rst_n_i) begin
            cycle_cnt_o <= '0;
        end else if (state_q == IDLE) begin
            if (start_i) begin
                cycle_cnt_o <= '0;
            end
        end else if (cycle_cnt_o != '1) begin
            cycle_cnt_o <= CNT_W'(cycle_cnt_o + CNT_W'(1));
        end
    end
`endif

endmodule
